rr_stream_arbiter: RTL and testbench
====================================

// Module: rr_stream_arbiter
// PURPOSE
//  - Round-robin arbiter sharing one downstream valid/ready stream between N upstream requesters.
//  - Packet-aware: once a requester is granted, it keeps the grant until its beat with last_f=1 transfers.
//  - Registered output stage with full throughput, same output handshake as our backward skid buffer.
//  - Sits in front of a backwardskidbuffer instance that feeds a shared sink.
// PARAMETERS
//  N    4   number of requesters, N>=2
//  L    8   data width per beat
//  IDW  $clog2(N)   localparam, width of id_b
//  CW   16  width of the completed-packet counter
// PORTS
//  clk        in   1     clock, all logic on posedge
//  rst        in   1     synchronous reset, active-high
//  valid_f    in   N     per-requester beat valid
//  data_f     in   N*L   per-requester data, requester i at [i*L +: L]
//  last_f     in   N     per-requester end-of-packet marker
//  ready_f    out  N     per-requester accept, at most one bit high
//  valid_b    out  1     downstream valid (registered)
//  data_b     out  L     downstream data (registered)
//  last_b     out  1     downstream end-of-packet (registered)
//  id_b       out  IDW   index of the requester that sourced the current beat (registered)
//  ready_b    in   1     downstream ready
//  pkt_cnt    out  CW    count of packets fully transferred from inputs, wraps at 2^CW
// BEHAVIOUR
//  - Reset values: valid_b=0, data_b=0, last_b=0, id_b=0, pkt_cnt=0, ptr=0, state=IDLE, owner=0.
//  - Output load: out_rdy = ready_b | ~valid_b, combinational.
//  - A beat from requester g transfers when ready_f[g] & valid_f[g].
//    On transfer, valid_b<=1, data_b<=data_f[g], last_b<=last_f[g], id_b<=g.
//    If out_rdy=1 and no transfer occurs, valid_b<=0 and the other output registers hold.
//    If out_rdy=0, all output registers hold.
//  - Latency is 1 clk from input transfer to valid_b. Throughput is 1 beat/clk.
//  - ready_f depends combinationally on valid_f, ready_b and state. valid_f does not depend on ready_f.
//  - State IDLE:
//    - g = first i with valid_f[i]=1, scanning from ptr upward modulo N.
//    - ready_f[g]=out_rdy. All other ready_f bits are 0.
//    - If no valid_f is high, ready_f=0 and the state holds.
//    - On transfer with last_f[g]=1: ptr<=(g+1)%N, pkt_cnt++, stay in IDLE.
//    - On transfer with last_f[g]=0: owner<=g, go to LOCKED.
//  - State LOCKED:
//    - ready_f[owner]=out_rdy. All other ready_f bits are 0, even if owner's valid_f=0 (bubble; no preemption).
//    - On owner transfer with last_f=1: ptr<=(owner+1)%N, pkt_cnt++, go to IDLE.
//    - On owner transfer with last_f=0: stay in LOCKED.
//  - ptr moves only on a packet end, never on an idle cycle.
//    A requester just served is the lowest priority in the next arbitration.
//  - Reset has priority over everything, including mid-packet.
//    After reset: IDLE, ptr=0, valid_b=0. The partial packet is dropped; no last_b is emitted for it.
//  - Upstream protocol: valid_f[i], data_f, last_f held stable until accepted. Not checked.
//  - pkt_cnt wraps from 2^CW-1 to 0. No saturation.
// TESTING
//  1 Reset: assert rst for 2 clk with all inputs high.
//    -> valid_b=0, pkt_cnt=0, ready_f=0 during rst.
//    -> First grant after release goes to requester 0.
//  2 Round-robin: all 4 valid, single-beat packets (last_f=1), ready_b=1.
//    -> id_b sequence 0,1,2,3,0,... one beat/clk.
//    -> pkt_cnt increments by 1 per clk.
//  3 Lock: req1 sends 3 beats (last on 3rd) while req0 and req2 are valid.
//    -> id_b=1,1,1, then 2.
//    -> ready_f[0] and ready_f[2] stay 0 throughout the lock.
//  4 Backpressure: ready_b=0 for 5 clk mid-stream.
//    -> valid_b, data_b, id_b stable; ready_f=0.
//    -> On ready_b=1, the next beat follows with no loss and no duplication.
//  5 Bubble in lock: owner drops valid_f for 2 clk mid-packet while others are valid.
//    -> No other requester granted; valid_b=0 after the drain; lock resumes.
//  6 Reset mid-packet: rst during LOCKED.
//    -> IDLE, valid_b=0 next clk.
//    -> pkt_cnt=0; grant order restarts at requester 0.

Source files
------------

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: packet-aware round-robin arbiter that merges N
// valid/ready upstream streams into one registered downstream stream.
// A requester keeps the grant from its first beat until its last beat
// transfers. The output stage uses a skid-free load condition
// (ready_b | ~valid_b), so a beat can be accepted on every clock.
module rr_stream_arbiter #(
    parameter  int N   = 4,
    parameter  int L   = 8,
    parameter  int CW  = 16,
    localparam int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     valid_f,
    input  logic [N*L-1:0]   data_f,
    input  logic [N-1:0]     last_f,
    output logic [N-1:0]     ready_f,
    output logic             valid_b,
    output logic [L-1:0]     data_b,
    output logic             last_b,
    output logic [IDW-1:0]   id_b,
    input  logic             ready_b,
    output logic [CW-1:0]    pkt_cnt
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state, state_nxt;
    logic [IDW-1:0]       ptr;       // highest-priority requester for the next arbitration
    logic [IDW-1:0]       owner;     // requester holding the grant while LOCKED
    logic [IDW-1:0]       gsel;      // requester currently offered the output
    logic [IDW-1:0]       scan_idx;
    logic                 found;
    logic                 out_rdy;
    logic                 xfer;
    logic                 xfer_last;
    logic [N-1:0][L-1:0]  data_arr;

    assign data_arr = data_f;

    // Output register may load when it is empty or being drained this cycle.
    assign out_rdy = ready_b | ~valid_b;

    // Pick the granted requester: the lock owner, or the first valid one from ptr upward.
    always_comb begin
        found    = 1'b0;
        gsel     = '0;
        scan_idx = '0;
        if (state == LOCKED) begin
            // Owner keeps the grant even while it bubbles; no preemption mid-packet.
            found = 1'b1;
            gsel  = owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                scan_idx = IDW'((int'(ptr) + k) % N);
                if (!found && valid_f[scan_idx]) begin
                    found = 1'b1;
                    gsel  = scan_idx;
                end
            end
        end
    end

    // Reset gates every accept so nothing leaks through while rst is held.
    assign xfer      = ~rst & found & valid_f[gsel] & out_rdy;
    assign xfer_last = xfer & last_f[gsel];

    // One-hot accept toward the granted requester only.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign ready_f[i] = ~rst & found & (gsel == IDW'(i)) & out_rdy;
    end

    // Next-state logic: lock on a non-final beat, release on the final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && !last_f[gsel]) state_nxt = LOCKED;
            LOCKED:  if (xfer_last)             state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Arbitration bookkeeping: lock owner, rotate priority and count packets on packet end.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            owner   <= '0;
            pkt_cnt <= '0;
        end else begin
            if (state == IDLE && xfer && !last_f[gsel])
                owner <= gsel;
            if (xfer_last) begin
                // Just-served requester becomes lowest priority.
                ptr     <= (gsel == IDW'(N - 1)) ? '0 : gsel + 1'b1;
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    // Registered output stage: load on transfer, drain when empty-able, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_b <= 1'b0;
            data_b  <= '0;
            last_b  <= 1'b0;
            id_b    <= '0;
        end else if (out_rdy) begin
            if (xfer) begin
                valid_b <= 1'b1;
                data_b  <= data_arr[gsel];
                last_b  <= last_f[gsel];
                id_b    <= gsel;
            end else begin
                valid_b <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed table-driven bench for rr_stream_arbiter (N=4, L=8, CW=4 so the
// packet counter wrap is reachable in a short run).
module tb_rr_stream_arbiter;

    localparam int N  = 4;
    localparam int L  = 8;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid_f;
    logic [N*L-1:0] data_f;
    logic [N-1:0]   last_f;
    logic [N-1:0]   ready_f;
    logic           valid_b;
    logic [L-1:0]   data_b;
    logic           last_b;
    logic [1:0]     id_b;
    logic           ready_b;
    logic [CW-1:0]  pkt_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    rr_stream_arbiter #(.N(N), .L(L), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .valid_f(valid_f), .data_f(data_f), .last_f(last_f), .ready_f(ready_f),
        .valid_b(valid_b), .data_b(data_b), .last_b(last_b), .id_b(id_b),
        .ready_b(ready_b), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] vf;
        logic [3:0] lf;
        logic       rb;
        logic [3:0] e_rf;   // ready_f expected before the edge
        logic       e_vb;   // registered outputs expected after the edge
        logic [1:0] e_id;
        logic       e_lb;
        logic [3:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic r, logic [3:0] vf, logic [3:0] lf, logic rb,
                                logic [3:0] erf, logic evb, logic [1:0] eid,
                                logic elb, logic [3:0] ecnt);
        vec_t v;
        v.rst = r; v.vf = vf; v.lf = lf; v.rb = rb;
        v.e_rf = erf; v.e_vb = evb; v.e_id = eid; v.e_lb = elb; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check combinational accept, then the registered result.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        rst     = v.rst;
        valid_f = v.vf;
        last_f  = v.lf;
        ready_b = v.rb;
        #1;
        chk({tag, ".ready_f"}, ready_f, v.e_rf);
        @(posedge clk);
        #1;
        chk({tag, ".valid_b"}, valid_b, v.e_vb);
        chk({tag, ".pkt_cnt"}, pkt_cnt, v.e_cnt);
        if (v.e_vb) begin
            chk({tag, ".id_b"},   id_b,   v.e_id);
            chk({tag, ".last_b"}, last_b, v.e_lb);
            chk({tag, ".data_b"}, data_b, 8'h10 + v.e_id);
        end
    endtask

    vec_t tv[29];

    initial begin
        // Requester i always presents data 0x10+i.
        data_f  = {8'h13, 8'h12, 8'h11, 8'h10};
        rst     = 1'b1;
        valid_f = '1;
        last_f  = '1;
        ready_b = 1'b1;

        //          rst vf     lf     rb  e_rf   vb id  lb cnt
        // reset with all inputs high
        tv[0]  = mk(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
        tv[1]  = mk(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
        // round robin, single-beat packets
        tv[2]  = mk(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 1);
        tv[3]  = mk(0, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 2);
        tv[4]  = mk(0, 4'hF, 4'hF, 1, 4'h4, 1, 2, 1, 3);
        tv[5]  = mk(0, 4'hF, 4'hF, 1, 4'h8, 1, 3, 1, 4);
        tv[6]  = mk(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 5);
        // req1 3-beat packet while req0/req2 valid
        tv[7]  = mk(0, 4'h7, 4'h5, 1, 4'h2, 1, 1, 0, 5);
        tv[8]  = mk(0, 4'h7, 4'h5, 1, 4'h2, 1, 1, 0, 5);
        tv[9]  = mk(0, 4'h7, 4'h7, 1, 4'h2, 1, 1, 1, 6);
        tv[10] = mk(0, 4'h5, 4'h5, 1, 4'h4, 1, 2, 1, 7);
        // backpressure for 5 clocks: output holds, no accepts
        tv[11] = mk(0, 4'hF, 4'hF, 0, 4'h0, 1, 2, 1, 7);
        tv[12] = mk(0, 4'hF, 4'hF, 0, 4'h0, 1, 2, 1, 7);
        tv[13] = mk(0, 4'hF, 4'hF, 0, 4'h0, 1, 2, 1, 7);
        tv[14] = mk(0, 4'hF, 4'hF, 0, 4'h0, 1, 2, 1, 7);
        tv[15] = mk(0, 4'hF, 4'hF, 0, 4'h0, 1, 2, 1, 7);
        tv[16] = mk(0, 4'hF, 4'hF, 1, 4'h8, 1, 3, 1, 8);
        tv[17] = mk(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 9);
        // bubble in lock: req1 owner drops valid for 2 clocks
        tv[18] = mk(0, 4'hF, 4'hD, 1, 4'h2, 1, 1, 0, 9);
        tv[19] = mk(0, 4'hD, 4'hD, 1, 4'h2, 0, 0, 0, 9);
        tv[20] = mk(0, 4'hD, 4'hD, 1, 4'h2, 0, 0, 0, 9);
        tv[21] = mk(0, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 10);
        // reset mid-packet from req2
        tv[22] = mk(0, 4'hF, 4'hB, 1, 4'h4, 1, 2, 0, 10);
        tv[23] = mk(1, 4'hF, 4'hB, 1, 4'h0, 0, 0, 0, 0);
        tv[24] = mk(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 1);
        tv[25] = mk(0, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 2);
        // idle cycle leaves ptr alone; scan wraps modulo N
        tv[26] = mk(0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 2);
        tv[27] = mk(0, 4'h1, 4'hF, 1, 4'h1, 1, 0, 1, 3);
        tv[28] = mk(0, 4'h9, 4'hF, 1, 4'h8, 1, 3, 1, 4);

        for (int i = 0; i < 29; i++)
            step(tv[i], $sformatf("v%0d", i));

        // Counter wrap: ptr=0, cnt=4; 12 single-beat packets take cnt through 15 to 0.
        for (int k = 0; k < 12; k++)
            step(mk(0, 4'hF, 4'hF, 1, 4'(1 << (k % 4)), 1, 2'(k % 4), 1, 4'((5 + k) % 16)),
                 $sformatf("wrap%0d", k));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
